// File: rtl/rr_arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// rr_arb_mux_pkg
// Shared sizing helpers and arbitration functions for rr_arb_mux.
// Revision: 1.0
// ============================================================================
package rr_arb_mux_pkg;

  localparam int MAX_CH  = 32;
  localparam int MAX_IDW = $clog2(MAX_CH);

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  function automatic int idw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

  // First valid channel at or after ptr, wrapping explicitly at n.
  function automatic pick_t rr_pick(input logic [MAX_CH-1:0] valid, input int ptr, input int n);
    pick_t p;
    int    c;
    p = '0;
    c = ptr;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n && !p.found && valid[c[MAX_IDW-1:0]]) begin
        p.found = 1'b1;
        p.idx   = c[MAX_IDW-1:0];
      end
      c = next_idx(c, n);
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb_mux_mux_2to1_w.sv
`default_nettype none
// ============================================================================
// mux_2to1_w
// W-bit two-input multiplexer, the leaf cell of the channel select tree.
// Revision: 1.0
// ============================================================================
module mux_2to1_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule
`default_nettype wire

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// rr_arb_mux
// N-channel arbitrating mux (round-robin or fixed priority) feeding a
// one-entry registered output stage with valid/ready handshakes.
// Revision: 1.0
// ============================================================================
module rr_arb_mux
  import rr_arb_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int W    = 8,
  localparam int IDW  = idw_of(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rr_en,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  localparam int LEAVES = 1 << IDW;

  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_data_q,  out_data_d;
  logic [IDW-1:0] out_id_q,    out_id_d;
  logic [IDW-1:0] ptr_q,       ptr_d;

  pick_t          pick;
  logic [IDW-1:0] grant_idx;
  logic           load;
  logic           xfer;
  logic [W-1:0]   sel_data;

  always_comb begin
    pick      = rr_pick(MAX_CH'(in_valid), rr_en ? int'(ptr_q) : 0, N_CH);
    grant_idx = IDW'(pick.idx);
    load      = !out_valid_q || out_ready;
    xfer      = load && pick.found && !rst;
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = xfer && (grant_idx == IDW'(i));
    end
  end

  // Heap-ordered select tree: node n has children 2n and 2n+1, leaves start at LEAVES.
  logic [W-1:0] node [1:2*LEAVES-1];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < N_CH) begin : g_used
      assign node[LEAVES+i] = in_data[i*W +: W];
    end else begin : g_pad
      assign node[LEAVES+i] = '0;
    end
  end

  for (genvar d = 0; d < IDW; d++) begin : g_lvl
    for (genvar j = 0; j < (1 << d); j++) begin : g_node
      mux_2to1_w #(.W(W)) u_mux (
        .d0  (node[2*((1 << d) + j)]),
        .d1  (node[2*((1 << d) + j) + 1]),
        .sel (grant_idx[IDW-1-d]),
        .y   (node[(1 << d) + j])
      );
    end
  end

  assign sel_data = node[1];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_id_d    = grant_idx;
      if (rr_en) begin
        ptr_d = IDW'(next_idx(int'(grant_idx), N_CH));
      end
    end else if (load) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule
`default_nettype wire
